// File: rtl/uart_tx_feeder.sv
// Transmit-side FIFO and sequencer feeding a UART transmitter through an en/busy/done handshake.
// A watchdog aborts bytes the transmitter never completes; overflow and timeout are sticky.
module uart_tx_feeder #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_level,
  output logic              o_overflow,
  output logic              o_tx_timeout,
  input  logic              i_clr_flags,
  output logic              o_tx_en,
  output logic [DATA_W-1:0] o_tx_data,
  input  logic              i_tx_busy,
  input  logic              i_tx_done
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone
  } state_e;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;

  state_e            r_state;
  logic              r_tx_en;
  logic [DATA_W-1:0] r_tx_data;
  logic [WD_W-1:0]   r_wd;
  logic              r_tx_timeout;

  logic              w_push;
  logic              w_pop;
  logic              w_wd_expire;
  logic [ADDR_W:0]   w_level_d;

  assign w_push      = i_wr_en && !r_full;
  assign w_pop       = (r_state == StIdle) && !r_empty;
  assign w_wd_expire = (r_wd == WD_W'(TIMEOUT - 1));

  always_comb begin
    w_level_d = r_level;
    if (w_push && !w_pop) begin
      w_level_d = r_level + (ADDR_W + 1)'(1);
    end else if (!w_push && w_pop) begin
      w_level_d = r_level - (ADDR_W + 1)'(1);
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_level <= w_level_d;
      r_full  <= (w_level_d == (ADDR_W + 1)'(DEPTH));
      r_empty <= (w_level_d == '0);
      if (i_wr_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (i_clr_flags) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_tx_en      <= 1'b0;
      r_tx_data    <= '0;
      r_wd         <= '0;
      r_tx_timeout <= 1'b0;
    end else begin
      // A timeout assignment later in this block overrides the clear.
      if (i_clr_flags) begin
        r_tx_timeout <= 1'b0;
      end
      case (r_state)
        StIdle: begin
          r_tx_en <= 1'b0;
          if (!r_empty) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_tx_en   <= 1'b1;
            r_wd      <= '0;
            r_state   <= StIssue;
          end
        end
        StIssue: begin
          if (r_wd != {WD_W{1'b1}}) begin
            r_wd <= r_wd + WD_W'(1);
          end
          if (i_tx_done) begin
            r_tx_en <= 1'b0;
            r_state <= StIdle;
          end else if (w_wd_expire) begin
            r_tx_en      <= 1'b0;
            r_tx_timeout <= 1'b1;
            r_state      <= StIdle;
          end else if (i_tx_busy) begin
            r_tx_en <= 1'b0;
            r_state <= StWaitDone;
          end
        end
        StWaitDone: begin
          r_tx_en <= 1'b0;
          if (r_wd != {WD_W{1'b1}}) begin
            r_wd <= r_wd + WD_W'(1);
          end
          if (i_tx_done) begin
            r_state <= StIdle;
          end else if (w_wd_expire) begin
            r_tx_timeout <= 1'b1;
            r_state      <= StIdle;
          end
        end
        default: begin
          r_tx_en <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_full       = r_full;
  assign o_empty      = r_empty;
  assign o_level      = r_level;
  assign o_overflow   = r_overflow;
  assign o_tx_timeout = r_tx_timeout;
  assign o_tx_en      = r_tx_en;
  assign o_tx_data    = r_tx_data;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: directed writes push expected bytes, a monitor checks
// each byte at the rise of tx_en; a small transmitter model answers with busy/done.
module tb_uart_tx_feeder;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_timeout;
  logic       clr_flags;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       m_busy;
  logic       m_done;
  logic       t_done;

  int         errs;
  int         checks;
  int         mode;
  int         bdly;
  int         ddly;
  bit         m_active;
  bit         gap_chk;
  logic [7:0] exp_q[$];

  assign tx_busy = m_busy;
  assign tx_done = m_done | t_done;

  uart_tx_feeder #(
    .DATA_W (8),
    .DEPTH  (16),
    .ADDR_W (4),
    .TIMEOUT(20)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_en     (wr_en),
    .i_wr_data   (wr_data),
    .o_full      (full),
    .o_empty     (empty),
    .o_level     (level),
    .o_overflow  (overflow),
    .o_tx_timeout(tx_timeout),
    .i_clr_flags (clr_flags),
    .o_tx_en     (tx_en),
    .o_tx_data   (tx_data),
    .i_tx_busy   (tx_busy),
    .i_tx_done   (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errs);
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit keep);
    wr_en   = 1'b1;
    wr_data = d;
    if (keep) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (empty && !tx_en && !m_active && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, 32'(ok), 1);
  endtask

  task automatic wait_model_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!m_active) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, 32'(ok), 1);
  endtask

  // Transmitter model: busy bdly cycles after seeing tx_en, done pulse ddly cycles later.
  initial begin
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_active = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_en && mode == 1) begin
        m_active = 1'b1;
        repeat (bdly) @(posedge clk);
        #1 m_busy = 1'b1;
        repeat (ddly) @(posedge clk);
        #1 m_done = 1'b1;
        @(posedge clk);
        #1 m_done = 1'b0;
        m_busy   = 1'b0;
        m_active = 1'b0;
      end
    end
  end

  // Monitor: every rise of tx_en must present the next expected byte.
  initial begin
    logic       prev_en;
    logic [7:0] exp;
    int         cyc;
    int         done_cyc;
    bit         done_pend;
    prev_en   = 1'b0;
    cyc       = 0;
    done_cyc  = 0;
    done_pend = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!gap_chk) done_pend = 1'b0;
      if (!rst_n) begin
        prev_en = 1'b0;
      end else begin
        if (tx_en && !prev_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_issue: tx_data 0x%0h with no byte expected at %0t",
                     tx_data, $time);
          end else begin
            exp = exp_q.pop_front();
            chk("tx_data_order", 32'(tx_data), 32'(exp));
          end
          if (gap_chk && done_pend) chk("idle_gap", 32'(cyc - done_cyc), 2);
          done_pend = 1'b0;
        end
        if (tx_done && !empty) begin
          done_cyc  = cyc;
          done_pend = 1'b1;
        end
        prev_en = tx_en;
      end
    end
  end

  initial begin
    bit seen;
    bit ok;
    errs      = 0;
    checks    = 0;
    mode      = 0;
    bdly      = 2;
    ddly      = 10;
    gap_chk   = 1'b0;
    t_done    = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    clr_flags = 1'b0;
    rst_n     = 1'b0;
    repeat (3) tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_timeout", 32'(tx_timeout), 0);
    chk("rst_tx_en", 32'(tx_en), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a transfer.
    mode = 1;
    bdly = 2;
    ddly = 10;
    push(8'hA5, 1);
    push(8'hB1, 1);
    push(8'hB2, 1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!tx_en) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("t1_reach_wait", 32'(ok), 1);
    chk("t1_level_pre", 32'(level), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_tx_en", 32'(tx_en), 0);
    chk("t1_async_level", 32'(level), 0);
    chk("t1_async_empty", 32'(empty), 1);
    chk("t1_async_tx_data", 32'(tx_data), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_en) seen = 1'b1;
    end
    chk("t1_no_issue_after_reset", 32'(seen), 0);
    wait_model_idle("t1_model_idle");

    // Single byte latency.
    push(8'h3C, 1);
    chk("t2_empty_after_n", 32'(empty), 0);
    chk("t2_tx_en_at_n", 32'(tx_en), 0);
    tick();
    chk("t2_tx_en_n1", 32'(tx_en), 1);
    chk("t2_tx_data_n1", 32'(tx_data), 32'h3C);
    tick();
    tick();
    chk("t2_tx_en_n3", 32'(tx_en), 1);
    tick();
    chk("t2_tx_en_drop_on_busy", 32'(tx_en), 0);
    repeat (9) tick();
    chk("t2_tx_en_wait_done", 32'(tx_en), 0);
    chk("t2_tx_data_held", 32'(tx_data), 32'h3C);
    tick();
    chk("t2_level_done", 32'(level), 0);
    wait_model_idle("t2_model_idle");

    // Fill and overflow while the first byte is stuck in issue.
    mode = 0;
    push(8'hEE, 1);
    for (int i = 0; i < 17; i++) push(8'(i), i < 16);
    chk("t3_level_full", 32'(level), 16);
    chk("t3_full", 32'(full), 1);
    chk("t3_overflow", 32'(overflow), 1);
    wr_en     = 1'b1;
    wr_data   = 8'h99;
    clr_flags = 1'b1;
    tick();
    wr_en     = 1'b0;
    clr_flags = 1'b0;
    chk("t3_set_beats_clear", 32'(overflow), 1);
    chk("t3_level_unchanged", 32'(level), 16);
    clear_flags();
    chk("t3_overflow_cleared", 32'(overflow), 0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_timeout) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("t3_first_byte_timeout", 32'(ok), 1);
    mode = 1;
    bdly = 1;
    ddly = 2;
    drain("t3_drain");

    // Simultaneous push and pop.
    clear_flags();
    chk("t5_flags_clear_ov", 32'(overflow), 0);
    chk("t5_flags_clear_to", 32'(tx_timeout), 0);
    mode = 0;
    push(8'h50, 1);
    for (int i = 1; i <= 5; i++) push(8'(8'h50 + i), 1);
    chk("t5_level_pre", 32'(level), 5);
    t_done = 1'b1;
    tick();
    t_done = 1'b0;
    chk("t5_done_in_issue", 32'(tx_en), 0);
    chk("t5_level_idle", 32'(level), 5);
    push(8'h56, 1);
    chk("t5_level_push_pop", 32'(level), 5);
    chk("t5_tx_en_pop", 32'(tx_en), 1);
    mode = 1;
    drain("t5_drain");

    // Watchdog abort, byte dropped, next byte issued on the following cycle.
    mode = 0;
    push(8'h77, 1);
    push(8'h88, 1);
    repeat (19) tick();
    chk("t6_tx_en_before", 32'(tx_en), 1);
    chk("t6_timeout_before", 32'(tx_timeout), 0);
    chk("t6_tx_data_before", 32'(tx_data), 32'h77);
    tick();
    chk("t6_timeout_set", 32'(tx_timeout), 1);
    chk("t6_tx_en_abort", 32'(tx_en), 0);
    tick();
    chk("t6_next_tx_en", 32'(tx_en), 1);
    chk("t6_next_tx_data", 32'(tx_data), 32'h88);
    mode = 1;
    drain("t6_drain");
    clear_flags();
    chk("t6_timeout_cleared", 32'(tx_timeout), 0);

    // Stream 40 bytes with wrap; one idle cycle between bytes while data is pending.
    gap_chk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int w;
      w = 0;
      while (full && w < 200) begin
        tick();
        w++;
      end
      if (w >= 200) chk("t4_full_stuck", 32'(full), 0);
      push(8'(i), 1);
    end
    drain("t4_drain");
    gap_chk = 1'b0;
    chk("t4_no_overflow", 32'(overflow), 0);
    chk("t4_no_timeout", 32'(tx_timeout), 0);
    chk("t4_scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Transmit-side buffer and sequencer that sits directly upstream of the UART transmitter. The host pushes bytes at any rate into an internal FIFO. The block pops one byte at a time and presents it to the transmitter with an enable/busy/done handshake. A watchdog recovers from a transmitter that never completes, and sticky flags report overflow and timeout.

Parameters:
DATA_W, 8, byte width carried to the transmitter
DEPTH, 16, FIFO entries (power of two)
ADDR_W, 4, log2(DEPTH)
TIMEOUT, 4095, max clock cycles from start of issue to tx_done before abort

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  host write strobe, one byte per cycle
wr_data  in  DATA_W  host byte
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
level  out  ADDR_W+1  current entry count, 0..DEPTH
overflow  out  1  sticky: write attempted while full
tx_timeout  out  1  sticky: watchdog aborted a byte
clr_flags  in  1  clears overflow and tx_timeout
tx_en  out  1  start request to transmitter
tx_data  out  DATA_W  byte to transmitter
tx_busy  in  1  transmitter busy
tx_done  in  1  transmitter one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous): FIFO pointers and level = 0; empty=1; full=0; overflow=0; tx_timeout=0; tx_en=0; tx_data=0; state=IDLE; watchdog=0. Takes effect immediately, mid-transfer included. The byte in flight is abandoned.
- FIFO: circular, ADDR_W-bit pointers that wrap DEPTH-1 -> 0.
  - A write is accepted when wr_en=1 and full=0 at the clock edge.
  - Write while full: data dropped, overflow set on that edge, FIFO unchanged.
  - No write-to-read bypass. A byte written at edge N is poppable no earlier than edge N+1.
  - Push and pop on the same edge: level unchanged, both pointers advance.
  - full, empty and level are registered and consistent with the pointers after each edge.
- Flags: clr_flags=1 clears both sticky flags. If a set event and clr_flags occur on the same edge, set wins.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE: tx_en=0. If empty=0: pop the head into the tx_data register, set tx_en=1, clear watchdog, go to ISSUE (all on the same edge).
  - ISSUE: tx_en=1, tx_data held. When tx_busy=1 is sampled, go to WAIT_DONE with tx_en=0.
    - If tx_done=1 is sampled while still in ISSUE, treat it as completion and go to IDLE with tx_en=0.
  - WAIT_DONE: tx_en=0, tx_data held. When tx_done=1 is sampled, go to IDLE.
  - tx_done or tx_busy seen in IDLE is ignored.
- Watchdog:
  - Increments each cycle in ISSUE and WAIT_DONE; saturates; cleared on entry to ISSUE.
  - When it reaches TIMEOUT, on that edge: tx_timeout set, tx_en=0, state=IDLE. The byte is dropped, not retried.
- Latency: with the FIFO empty and state IDLE, a write at edge N gives empty=0 after N. The pop occurs at edge N+1, so tx_en=1 and tx_data are valid after N+1.
- Throughput: after tx_done is sampled at edge M with bytes pending, return to IDLE at M. The next pop and tx_en occur at M+1, giving one idle cycle between bytes.
- tx_data is stable from the rise of tx_en until the FSM returns to IDLE. It changes only on a pop.

Test Plan:
1. Reset mid-transfer: write 0xA5, reach WAIT_DONE, pulse reset=0 -> tx_en=0, level=0, empty=1, tx_data=0 immediately. No issue follows after release.
2. Single byte latency: write 0x3C at edge N into an idle block; model asserts tx_busy 2 cycles after tx_en and tx_done 10 cycles later -> tx_en=1 and tx_data=0x3C after N+1; tx_en drops when busy is seen; back to IDLE on done.
3. Fill and overflow: 17 back-to-back writes 0x00..0x10 with tx_busy held 0 and no done -> level=16, full=1, overflow=1, byte 0x10 lost. clr_flags then clears overflow.
4. Ordering and wrap: stream 40 bytes 0x00..0x27 through a responsive model -> transmitter receives exactly 0x00..0x27 in order; pointers wrap twice; one idle cycle between successive tx_en.
5. Simultaneous push/pop: level=5 and a write on the same edge as an IDLE pop -> level stays 5.
6. Watchdog: TIMEOUT=20, model never asserts tx_done -> at 20 cycles after issue, tx_timeout=1 and tx_en=0. The next byte is issued on the following cycle.
